mdu_stall_src: RTL
==================

# mdu_stall_src

Multi-cycle multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers, runs mult/multu/div/divu over a fixed number of cycles, and executes mthi/mtlo in a single cycle. It is the source of the MDU stall condition consumed by the hazard unit: it raises `stall_req` whenever the D-stage instruction needs HI/LO or the MDU while an operation is starting or in flight.

## Interface

Parameters:
- `MULT_CYCLES`, default 5, busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10, busy cycles for div/divu (must be ≥1).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  E-stage MDU instruction valid. It is already gated by FlushE outside the block.
- `op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 are no-op.
- `a`  in  32  forwarded rs value from E.
- `b`  in  32  forwarded rt value from E.
- `md_D`  in  1  D-stage instruction is any MDU-class instruction (mult*, div*, mfhi, mflo, mthi, mtlo).
- `busy`  out  1  a multi-cycle operation is in progress.
- `stall_req`  out  1  stall request to the hazard unit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- State: `cnt` (width sized for the larger of `MULT_CYCLES` and `DIV_CYCLES`), latched operands, latched op, and the `hi`/`lo` registers.
- Two states:
  - IDLE when `cnt`==0.
  - RUN when `cnt`!=0.
- `busy` = (`cnt`!=0), a registered-state output.
- Start of a mult/multu/div/divu in IDLE:
  - latch `a`, `b` and `op`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
- RUN:
  - `cnt` decrements on every edge;
  - on the edge where `cnt` goes 1→0, write the result to `hi`/`lo`.
- mult: signed 32×32→64. `hi`=[63:32], `lo`=[31:0].
- multu: unsigned 32×32→64, same split as mult.
- div: signed.
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- divu: unsigned; `lo` = quotient, `hi` = remainder.
- Divide by zero (`b`==0): `busy` runs the full `DIV_CYCLES`; `hi`/`lo` are left unchanged.
- mthi / mtlo in IDLE: `hi` (or `lo`) ← `a` at the next edge; `busy` stays 0.
- `start` while RUN is ignored: no state change. The bench flags it as an error, because `stall_req` guarantees it cannot happen.
- `stall_req` = `md_D` & (`start` | `busy`). This is combinational, so it covers the issue cycle itself.
- mfhi/mflo are not handled here. E reads `hi`/`lo` directly, and `stall_req` ensures they are stable at that point.

## Timing

- Reset values: `hi`=0, `lo`=0, `busy`=0, `cnt`=0. `stall_req` is 0 unless `md_D` & `start`.
- Reset assertion mid-operation aborts immediately: `cnt`=0, and `hi`/`lo` are cleared to 0.
- Sequence for a start sampled at edge t0 with N cycles:
  - `busy` is 1 after t0 through edge t0+N;
  - `busy` is 0 after t0+N;
  - `hi`/`lo` are updated at edge t0+N.
- Total `stall_req` window for a dependent `md_D` held high: N+1 cycles (the issue cycle plus N busy cycles).
- mthi/mtlo latency is 1 edge, with no stall. A back-to-back mfhi in D sees `stall_req`=1 for one cycle only.
- A new start in the cycle right after `busy` falls is accepted.

## Configuration

- `MDU_DIV_EN` defined: div and divu are implemented as above.
- `MDU_DIV_EN` undefined:
  - op 2 and op 3 are treated as no-op: no `busy`, `hi`/`lo` unchanged;
  - the divider logic is not built;
  - `stall_req` still asserts in the issue cycle whenever `md_D` & `start`.

## Test plan

- mult, `a`=0xFFFFFFFF, `b`=2 → `busy` high for 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- multu, `a`=0xFFFFFFFF, `b`=2 → after 5 cycles `hi`=0x00000001, `lo`=0xFFFFFFFE.
- div, `a`=0xFFFFFFF9 (−7), `b`=2 → `busy` for 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Repeat with divu, `a`=7, `b`=0 → `hi`/`lo` unchanged after 10 cycles.
- div start with `md_D`=1 held → `stall_req`=1 for exactly 11 consecutive cycles, then 0. A second `start` during the busy cycles is ignored.
- mthi with `a`=0x12345678 → `hi`=0x12345678 one edge later; `busy` stays 0.
- Rollback checks:
  - `rst_n` pulsed low during cycle 4 of a div → `busy`=0 and `hi`=`lo`=0 immediately.
  - With `MDU_DIV_EN` undefined, a div start → `busy` stays 0.

Source files
------------

// File: rtl/mdu_stall_src.sv
// mdu_stall_src: E-stage multiply/divide unit owning HI/LO.
// mult/multu/div/divu run for a fixed number of cycles; mthi/mtlo complete
// in one edge. stall_req tells the hazard unit to hold an MDU-class
// instruction in D while an operation is issuing or in flight.
// Optional feature macro: MDU_DIV_EN builds the divider (div/divu). Without
// it, ops 2 and 3 behave as no-ops.
//
// Handshake: there is no ready output. An E-stage start is accepted only in
// IDLE; a start while RUN is dropped with no state change. The hazard unit
// keeps that from happening by stalling D whenever stall_req is high.
module mdu_stall_src #(
  parameter int MULT_CYCLES = 5,  // >= 1
  parameter int DIV_CYCLES  = 10  // >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
`endif
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // The busy counter is the real state; the enum is its decoded view.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;
  logic [31:0]   hi_nxt, lo_nxt;
  logic          latch_en;
  logic [63:0]   prod_s, prod_u, res;
  logic          res_wr;

  // Decode the FSM state from the counter.
  always_comb state = (cnt == '0) ? ST_IDLE : ST_RUN;

  assign busy      = (state == ST_RUN);
  assign stall_req = md_D & (start | busy);

  // Both products from the latched operands; the signed one uses sign-extended
  // operands so the low 64 bits are the correct two's-complement result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

`ifdef MDU_DIV_EN
  logic        is_sdiv, neg_q, neg_r;
  logic [31:0] a_abs, b_abs, q_mag, r_mag, quo, rem;

  // Signed divide through magnitudes: truncates toward zero, remainder takes
  // the dividend's sign, and 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    is_sdiv = (op_q == OP_DIV);
    neg_q   = is_sdiv & (a_q[31] ^ b_q[31]);
    neg_r   = is_sdiv & a_q[31];
    a_abs   = (is_sdiv && a_q[31]) ? -a_q : a_q;
    b_abs   = (is_sdiv && b_q[31]) ? -b_q : b_q;
    q_mag   = a_abs / b_abs;
    r_mag   = a_abs % b_abs;
    quo     = neg_q ? -q_mag : q_mag;
    rem     = neg_r ? -r_mag : r_mag;
  end
`endif

  // Select the completion result and whether it may be written to HI/LO.
  always_comb begin
    res    = (op_q == OP_MULT) ? prod_s : prod_u;
    res_wr = 1'b1;
`ifdef MDU_DIV_EN
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      res    = {rem, quo};
      res_wr = (b_q != '0);  // divide by zero leaves HI/LO untouched
    end
`endif
  end

  // Next-state: accept starts in IDLE, count down in RUN, write on 1->0.
  always_comb begin
    cnt_nxt  = cnt;
    hi_nxt   = hi;
    lo_nxt   = lo;
    latch_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              latch_en = 1'b1;
              cnt_nxt  = CW'(MULT_CYCLES);
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              latch_en = 1'b1;
              cnt_nxt  = CW'(DIV_CYCLES);
            end
`endif
            OP_MTHI: hi_nxt = a;
            OP_MTLO: lo_nxt = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1) && res_wr) begin
          hi_nxt = res[63:32];
          lo_nxt = res[31:0];
        end
      end
      default: ;
    endcase
  end

  // State, operand latches and HI/LO; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      cnt <= cnt_nxt;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      if (latch_en) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
    end
  end

endmodule
